// File: rtl/imem_fetch_buf.sv
// Byte-addressed instruction memory with a valid/ready fetch port, one-cycle read latency,
// a two-entry output/skid buffer, fault flags, flush, a byte-wide program-load port and a fetch counter.
module imem_fetch_buf #(
   parameter int unsigned ADDR_W      = 64,
   parameter int unsigned DEPTH_BYTES = 256,
   parameter bit          BIG_ENDIAN  = 1'b1,
   parameter              INIT_FILE   = "",
   parameter int unsigned CNT_W       = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [ADDR_W-1:0]              req_pc,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [31:0]                    rsp_instr,
   output logic [ADDR_W-1:0]              rsp_pc,
   output logic [1:0]                     rsp_err,
   input  logic                           flush,
   input  logic                           prog_we,
   input  logic [$clog2(DEPTH_BYTES)-1:0] prog_addr,
   input  logic [7:0]                     prog_data,
   output logic [CNT_W-1:0]               fetch_cnt
);

   localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH_BYTES - 4);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       instr;
      logic [1:0]        err;
   } entry_t;

   // Buffer occupancy: FULL means both the output and the skid register hold responses.
   typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

   logic [7:0] mem [DEPTH_BYTES];

   occ_t       occ, occ_next;
   entry_t     out_q, skid_q, new_e;
   logic       accept, consume;
   logic       load_out, load_skid, move_skid;
   logic [IDX_W-1:0] idx;
   logic [7:0] b0, b1, b2, b3;

   always_ff @(posedge clk) begin
      if (prog_we) mem[prog_addr] <= prog_data;
   end

   // Byte lanes are only meaningful when the PC is in range, so index wrap is harmless.
   always_comb begin
      idx       = req_pc[IDX_W-1:0];
      b0        = mem[idx];
      b1        = mem[idx + IDX_W'(1)];
      b2        = mem[idx + IDX_W'(2)];
      b3        = mem[idx + IDX_W'(3)];
      new_e     = '0;
      new_e.pc  = req_pc;
      if (req_pc[1:0] != 2'b00) begin
         new_e.err = 2'b01;
      end else if (req_pc > LAST_PC) begin
         new_e.err = 2'b10;
      end else if (BIG_ENDIAN) begin
         new_e.instr = {b0, b1, b2, b3};
      end else begin
         new_e.instr = {b3, b2, b1, b0};
      end
   end

   assign rsp_valid = (occ != EMPTY);
   assign req_ready = (occ != FULL) && !prog_we;
   assign accept    = req_valid && req_ready && !flush;
   assign consume   = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) occ <= EMPTY;
      else        occ <= occ_next;
   end

   // An accept is impossible in FULL because req_ready is low there.
   always_comb begin
      occ_next  = occ;
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      if (flush) begin
         occ_next = EMPTY;
      end else begin
         case (occ)
            EMPTY: begin
               if (accept) begin
                  load_out = 1'b1;
                  occ_next = ONE;
               end
            end
            ONE: begin
               if (consume && accept) begin
                  load_out = 1'b1;
               end else if (consume) begin
                  occ_next = EMPTY;
               end else if (accept) begin
                  load_skid = 1'b1;
                  occ_next  = FULL;
               end
            end
            FULL: begin
               if (consume) begin
                  move_skid = 1'b1;
                  occ_next  = ONE;
               end
            end
            default: occ_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out)       out_q <= new_e;
         else if (move_skid) out_q <= skid_q;
         if (load_skid)      skid_q <= new_e;
      end
   end

   assign rsp_instr = out_q.instr;
   assign rsp_pc    = out_q.pc;
   assign rsp_err   = out_q.err;

   // Counts every handshake, including one that coincides with a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          fetch_cnt <= '0;
      else if (consume && fetch_cnt != '1) fetch_cnt <= fetch_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_imem_fetch_buf.sv
// Bench for imem_fetch_buf: a big-endian and a little-endian instance share stimulus and are checked
// against a queue-based response model; the little-endian instance uses a 3-bit counter to hit saturation.
module tb_imem_fetch_buf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, rsp_ready, flush, prog_we;
   logic [63:0] req_pc;
   logic [7:0]  prog_addr, prog_data;

   logic        req_ready_be, rsp_valid_be, req_ready_le, rsp_valid_le;
   logic [31:0] rsp_instr_be, rsp_instr_le;
   logic [63:0] rsp_pc_be, rsp_pc_le;
   logic [1:0]  rsp_err_be, rsp_err_le;
   logic [31:0] fetch_cnt_be;
   logic [2:0]  fetch_cnt_le;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] be;
      logic [31:0] le;
      logic [1:0]  err;
   } rsp_t;

   logic [7:0]  mdl_mem [256];
   rsp_t        q[$];
   logic [31:0] cnt_be;
   logic [2:0]  cnt_le;

   always #5 clk = ~clk;

   imem_fetch_buf #(.ADDR_W(64), .DEPTH_BYTES(256), .BIG_ENDIAN(1'b1), .INIT_FILE(""), .CNT_W(32)) dut_be (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_be), .req_pc(req_pc),
      .rsp_valid(rsp_valid_be), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr_be), .rsp_pc(rsp_pc_be),
      .rsp_err(rsp_err_be), .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .fetch_cnt(fetch_cnt_be));

   imem_fetch_buf #(.ADDR_W(64), .DEPTH_BYTES(256), .BIG_ENDIAN(1'b0), .INIT_FILE(""), .CNT_W(3)) dut_le (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_le), .req_pc(req_pc),
      .rsp_valid(rsp_valid_le), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr_le), .rsp_pc(rsp_pc_le),
      .rsp_err(rsp_err_le), .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .fetch_cnt(fetch_cnt_le));

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Word contents derived straight from the fault and endianness rules.
   function automatic rsp_t modelFetch(input logic [63:0] pc);
      rsp_t r;
      r.pc  = pc;
      r.be  = '0;
      r.le  = '0;
      r.err = 2'b00;
      if (pc % 4 != 0) begin
         r.err = 2'b01;
      end else if (pc > 64'd252) begin
         r.err = 2'b10;
      end else begin
         for (int k = 0; k < 4; k++) begin
            r.be = {r.be[23:0], mdl_mem[int'(pc) + k]};
            r.le = {mdl_mem[int'(pc) + k], r.le[31:8]};
         end
      end
      return r;
   endfunction

   task automatic checkState();
      checkOutput("rsp_valid_be", 64'(rsp_valid_be), 64'(q.size() > 0));
      checkOutput("rsp_valid_le", 64'(rsp_valid_le), 64'(q.size() > 0));
      checkOutput("fetch_cnt_be", 64'(fetch_cnt_be), 64'(cnt_be));
      checkOutput("fetch_cnt_le", 64'(fetch_cnt_le), 64'(cnt_le));
      if (q.size() > 0) begin
         checkOutput("rsp_instr_be", 64'(rsp_instr_be), 64'(q[0].be));
         checkOutput("rsp_instr_le", 64'(rsp_instr_le), 64'(q[0].le));
         checkOutput("rsp_pc_be", rsp_pc_be, q[0].pc);
         checkOutput("rsp_pc_le", rsp_pc_le, q[0].pc);
         checkOutput("rsp_err_be", 64'(rsp_err_be), 64'(q[0].err));
         checkOutput("rsp_err_le", 64'(rsp_err_le), 64'(q[0].err));
      end
   endtask

   // One clock of stimulus; returns one time unit after the rising edge with the model updated.
   task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic rr, input logic fl,
                                input logic we, input logic [7:0] wa, input logic [7:0] wd);
      logic exp_rdy, acc, con;
      @(negedge clk);
      checkState();
      req_valid = v;
      req_pc    = pc;
      rsp_ready = rr;
      flush     = fl;
      prog_we   = we;
      prog_addr = wa;
      prog_data = wd;
      #1;
      exp_rdy = (q.size() < 2) && !we;
      checkOutput("req_ready_be", 64'(req_ready_be), 64'(exp_rdy));
      checkOutput("req_ready_le", 64'(req_ready_le), 64'(exp_rdy));
      @(posedge clk);
      #1;
      con = (q.size() > 0) && rr;
      acc = v && exp_rdy && !fl;
      if (con) begin
         void'(q.pop_front());
         if (cnt_be != 32'hFFFF_FFFF) cnt_be++;
         if (cnt_le != 3'd7) cnt_le++;
      end
      if (fl) q.delete();
      else if (acc) q.push_back(modelFetch(pc));
      if (we) mdl_mem[wa] = wd;
   endtask

   task automatic fetch(input logic [63:0] pc, input logic rr);
      applyStimulus(1'b1, pc, rr, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic idle(input logic rr);
      applyStimulus(1'b0, 64'h0, rr, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic clearInputs();
      req_valid = 1'b0;
      req_pc    = '0;
      rsp_ready = 1'b0;
      flush     = 1'b0;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;
   endtask

   logic [7:0]  img [4];
   logic [63:0] fault_pc [4];
   logic [1:0]  fault_err [4];
   logic [31:0] saved_cnt;
   logic [63:0] rpc;
   int          sel;

   initial begin
      img       = '{8'h8B, 8'h1F, 8'h03, 8'hE0};
      fault_pc  = '{64'd2, 64'd254, 64'd256, 64'hFFFF_FFFF_FFFF_FFFC};
      fault_err = '{2'b01, 2'b01, 2'b10, 2'b10};
      cnt_be    = '0;
      cnt_le    = '0;
      clearInputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_valid", 64'(rsp_valid_be), 64'd0);
      checkOutput("reset_instr", 64'(rsp_instr_be), 64'd0);
      checkOutput("reset_pc", rsp_pc_be, 64'd0);
      checkOutput("reset_err", 64'(rsp_err_be), 64'd0);
      checkOutput("reset_cnt", 64'(fetch_cnt_be), 64'd0);
      checkOutput("reset_ready", 64'(req_ready_be), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Load the whole array so every model byte is known; the first word is the reference image.
      for (int a = 0; a < 256; a++)
         applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 8'(a), (a < 4) ? img[a] : 8'($urandom));

      fetch(64'd0, 1'b1);
      checkOutput("first_instr_be", 64'(rsp_instr_be), 64'h8B1F03E0);
      checkOutput("first_instr_le", 64'(rsp_instr_le), 64'hE0031F8B);
      checkOutput("first_err", 64'(rsp_err_be), 64'd0);
      idle(1'b1);
      checkOutput("first_cnt", 64'(fetch_cnt_be), 64'd1);

      // Back-to-back with the consumer stalled, then drain.
      fetch(64'd0, 1'b0);
      fetch(64'd4, 1'b0);
      checkOutput("b2b_ready_low", 64'(req_ready_be), 64'd0);
      fetch(64'd8, 1'b0);
      fetch(64'd8, 1'b1);
      checkOutput("b2b_drain_pc4", rsp_pc_be, 64'd4);
      fetch(64'd8, 1'b1);
      checkOutput("b2b_pc8", rsp_pc_be, 64'd8);
      idle(1'b1);

      for (int i = 0; i < 4; i++) begin
         fetch(fault_pc[i], 1'b1);
         checkOutput("fault_err", 64'(rsp_err_be), 64'(fault_err[i]));
         checkOutput("fault_instr", 64'(rsp_instr_be), 64'd0);
      end
      idle(1'b1);
      idle(1'b1);

      fetch(64'd16, 1'b0);
      fetch(64'd20, 1'b0);
      saved_cnt = fetch_cnt_be;
      applyStimulus(1'b1, 64'd24, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      checkOutput("flush_valid", 64'(rsp_valid_be), 64'd0);
      checkOutput("flush_cnt", 64'(fetch_cnt_be), 64'(saved_cnt));
      idle(1'b1);

      for (int i = 0; i < 600; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 7)       rpc = 64'($urandom_range(0, 63)) * 64'd4;
         else if (sel == 7) rpc = 64'($urandom_range(0, 255));
         else if (sel == 8) rpc = {$urandom, $urandom};
         else               rpc = 64'd256 + 64'($urandom_range(0, 255)) * 64'd4;
         applyStimulus($urandom_range(0, 99) < 70, rpc, $urandom_range(0, 99) < 55,
                       $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 6,
                       8'($urandom), 8'($urandom));
      end

      // Asynchronous reset between clock edges with responses buffered.
      idle(1'b1);
      idle(1'b1);
      fetch(64'd32, 1'b0);
      fetch(64'd36, 1'b0);
      @(negedge clk);
      clearInputs();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_valid_be", 64'(rsp_valid_be), 64'd0);
      checkOutput("async_valid_le", 64'(rsp_valid_le), 64'd0);
      checkOutput("async_cnt_be", 64'(fetch_cnt_be), 64'd0);
      checkOutput("async_cnt_le", 64'(fetch_cnt_le), 64'd0);
      checkOutput("async_instr", 64'(rsp_instr_be), 64'd0);
      q.delete();
      cnt_be = '0;
      cnt_le = '0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) fetch(64'(i) * 64'd4, 1'b1);
      idle(1'b1);
      @(negedge clk);
      checkState();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
